// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the execute stage.
//
// Performs signed or unsigned DATA_W-bit division in DATA_W+1 cycles after
// the accept edge and presents {remainder, quotient} on result_o together
// with ready_o. A zero divisor short-circuits to a zero result after one
// edge. An in-flight division can be dropped with annul_i.
//
// Optional build macro: DIV_BYZERO_FLAG_EN
//   When defined, an extra registered output divzero_o flags results that
//   came from a zero divisor. When undefined the port does not exist.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
`ifdef DIV_BYZERO_FLAG_EN
    ,
    output logic                  divzero_o
`endif
);

    // Iteration counter must be able to hold the value DATA_W itself.
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [DATA_W-1:0]      divisor_reg;     // divisor magnitude
    logic [2*DATA_W:0]      partial_reg;     // {partial remainder, dividend/quotient}
    logic                   neg_dvd_reg;     // dividend sign at accept
    logic                   neg_dvs_reg;     // divisor sign at accept
    logic                   signed_reg;      // signed_div_i at accept

    // Operand magnitudes, only meaningful at the accept edge.
    logic [DATA_W-1:0]      dvd_mag;
    logic [DATA_W-1:0]      dvs_mag;

    // One restoring step.
    logic [DATA_W+1:0]      trial_diff;
    logic [2*DATA_W:0]      partial_next;

    // Final sign-corrected values.
    logic [DATA_W-1:0]      quot_mag;
    logic [DATA_W-1:0]      rem_mag;
    logic [DATA_W-1:0]      quot_fix;
    logic [DATA_W-1:0]      rem_fix;

    // Convert negative signed operands to magnitude before they are latched.
    always_comb begin
        dvd_mag = opdata1_i;
        dvs_mag = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            dvd_mag = -opdata1_i;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            dvs_mag = -opdata2_i;
        end
    end

    // Shift-left-by-one and trial-subtract the divisor in a single step.
    // The upper DATA_W+1 bits of the partial remainder plus the next dividend
    // bit form the shifted window; a clear sign bit on the difference means
    // the subtraction is kept and a quotient 1 is shifted in.
    always_comb begin
        trial_diff   = partial_reg[2*DATA_W:DATA_W-1] - {2'b00, divisor_reg};
        partial_next = {partial_reg[2*DATA_W-1:0], 1'b0};
        if (!trial_diff[DATA_W+1]) begin
            partial_next = {trial_diff[DATA_W:0], partial_reg[DATA_W-2:0], 1'b1};
        end
    end

    // Restore signs: quotient negative when operand signs differ, remainder
    // follows the dividend. The most-negative / -1 case falls out naturally
    // as a quotient magnitude of 2^(DATA_W-1) with no negation.
    always_comb begin
        quot_mag = partial_reg[DATA_W-1:0];
        rem_mag  = partial_reg[2*DATA_W-1:DATA_W];
        quot_fix = quot_mag;
        rem_fix  = rem_mag;
        if (signed_reg && (neg_dvd_reg ^ neg_dvs_reg)) begin
            quot_fix = -quot_mag;
        end
        if (signed_reg && neg_dvd_reg) begin
            rem_fix = -rem_mag;
        end
    end

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            divisor_reg <= '0;
            partial_reg <= '0;
            neg_dvd_reg <= 1'b0;
            neg_dvs_reg <= 1'b0;
            signed_reg  <= 1'b0;
            result_o    <= '0;
            ready_o     <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            divzero_o   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A start accompanied by annul is treated as no request.
                    if (start_i && !annul_i) begin
                        divisor_reg <= dvs_mag;
                        partial_reg <= {{(DATA_W+1){1'b0}}, dvd_mag};
                        neg_dvd_reg <= opdata1_i[DATA_W-1];
                        neg_dvs_reg <= opdata2_i[DATA_W-1];
                        signed_reg  <= signed_div_i;
                        cnt_reg     <= '0;
                        if (opdata2_i == '0) begin
                            state_reg <= ST_BYZERO;
                        end else begin
                            state_reg <= ST_ON;
                        end
                    end
                end

                ST_BYZERO: begin
                    if (annul_i) begin
                        state_reg <= ST_IDLE;
                        result_o  <= '0;
                        ready_o   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                        divzero_o <= 1'b0;
`endif
                    end else begin
                        state_reg <= ST_END;
                        result_o  <= '0;
                        ready_o   <= 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                        divzero_o <= 1'b1;
`endif
                    end
                end

                ST_ON: begin
                    if (annul_i) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        result_o  <= '0;
                        ready_o   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                        divzero_o <= 1'b0;
`endif
                    end else if (cnt_reg == LAST_CNT) begin
                        // All quotient bits are in; publish the corrected result.
                        state_reg <= ST_END;
                        result_o  <= {rem_fix, quot_fix};
                        ready_o   <= 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                        divzero_o <= 1'b0;
`endif
                    end else begin
                        partial_reg <= partial_next;
                        cnt_reg     <= cnt_reg + CNT_W'(1);
                    end
                end

                ST_END: begin
                    // Result is held for as long as execute keeps start high.
                    if (!start_i) begin
                        state_reg <= ST_IDLE;
                        result_o  <= '0;
                        ready_o   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                        divzero_o <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    result_o  <= '0;
                    ready_o   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                    divzero_o <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized self-checking bench for div_iter.
// Two instances (DATA_W=32 and DATA_W=8) run against an arithmetic model.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        start32, annul32, sgn32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32;
    // 8-bit instance
    logic        start8, annul8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8;
`ifdef DIV_BYZERO_FLAG_EN
    logic        dz32, dz8;
`endif

    div_iter #(.DATA_W(32)) dut32 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start32),
        .annul_i      (annul32),
        .signed_div_i (sgn32),
        .opdata1_i    (a32),
        .opdata2_i    (b32),
        .result_o     (res32),
        .ready_o      (rdy32)
`ifdef DIV_BYZERO_FLAG_EN
        ,
        .divzero_o    (dz32)
`endif
    );

    div_iter #(.DATA_W(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start8),
        .annul_i      (annul8),
        .signed_div_i (sgn8),
        .opdata1_i    (a8),
        .opdata2_i    (b8),
        .result_o     (res8),
        .ready_o      (rdy8)
`ifdef DIV_BYZERO_FLAG_EN
        ,
        .divzero_o    (dz8)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division with plain integer arithmetic; returns {rem, quot}
    // packed in the low 2*w bits.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input int w);
        logic [63:0] mask;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        if ((64'(b) & mask) == 64'd0) return 64'd0;
        sa = longint'(64'(a) & mask);
        sb = longint'(64'(b) & mask);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        q = sa / sb;
        r = sa % sb;
        return ((64'(r) & mask) << w) | (64'(q) & mask);
    endfunction

    // Transaction-level model: idle / counting down / holding result.
    logic [63:0] m32_res, m32_pend;
    logic        m32_rdy, m32_dz, m32_pend_dz;
    int          m32_busy;
    always @(posedge clk) begin
        if (rst) begin
            m32_busy <= 0; m32_rdy <= 1'b0; m32_res <= 64'd0; m32_dz <= 1'b0;
        end else if (m32_rdy) begin
            if (!start32) begin m32_rdy <= 1'b0; m32_res <= 64'd0; m32_dz <= 1'b0; end
        end else if (m32_busy > 0) begin
            if (annul32) m32_busy <= 0;
            else if (m32_busy == 1) begin
                m32_busy <= 0; m32_rdy <= 1'b1; m32_res <= m32_pend; m32_dz <= m32_pend_dz;
            end else m32_busy <= m32_busy - 1;
        end else if (start32 && !annul32) begin
            m32_pend    <= ref_div(a32, b32, sgn32, 32);
            m32_pend_dz <= (b32 == 32'd0);
            m32_busy    <= (b32 == 32'd0) ? 1 : 33;
        end
    end

    logic [15:0] m8_res, m8_pend;
    logic        m8_rdy, m8_dz, m8_pend_dz;
    int          m8_busy;
    always @(posedge clk) begin
        if (rst) begin
            m8_busy <= 0; m8_rdy <= 1'b0; m8_res <= 16'd0; m8_dz <= 1'b0;
        end else if (m8_rdy) begin
            if (!start8) begin m8_rdy <= 1'b0; m8_res <= 16'd0; m8_dz <= 1'b0; end
        end else if (m8_busy > 0) begin
            if (annul8) m8_busy <= 0;
            else if (m8_busy == 1) begin
                m8_busy <= 0; m8_rdy <= 1'b1; m8_res <= m8_pend; m8_dz <= m8_pend_dz;
            end else m8_busy <= m8_busy - 1;
        end else if (start8 && !annul8) begin
            m8_pend    <= ref_div({24'd0, a8}, {24'd0, b8}, sgn8, 8) & 16'hFFFF;
            m8_pend_dz <= (b8 == 8'd0);
            m8_busy    <= (b8 == 8'd0) ? 1 : 9;
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy32", 64'(rdy32), 64'(m32_rdy));
            chk("res32", res32, m32_res);
            chk("rdy8", 64'(rdy8), 64'(m8_rdy));
            chk("res8", 64'(res8), 64'(m8_res));
`ifdef DIV_BYZERO_FLAG_EN
            chk("dz32", 64'(dz32), 64'(m32_dz));
            chk("dz8", 64'(dz8), 64'(m8_dz));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Full 32-bit transaction; lat = edges from accept to ready.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, output logic [63:0] res, output logic [63:0] res_end,
                         output int lat);
        int n;
        start32 = 1'b1; a32 = a; b32 = b; sgn32 = s; n = 0;
        forever begin
            step(); n++;
            if (rdy32) break;
            if (n > 200) begin chk("run32_timeout", 64'(rdy32), 64'd1); break; end
        end
        lat = n - 1;
        res = res32;
        for (int i = 0; i < hold; i++) begin
            a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
            step();
        end
        res_end = res32;
        start32 = 1'b0;
        step();
        $display("div32 a=%h b=%h s=%0d -> res=%h lat=%0d", a, b, s, res, lat);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] res, output int lat);
        int n;
        start8 = 1'b1; a8 = a; b8 = b; sgn8 = s; n = 0;
        forever begin
            step(); n++;
            if (rdy8) break;
            if (n > 100) begin chk("run8_timeout", 64'(rdy8), 64'd1); break; end
        end
        lat = n - 1;
        res = res8;
        start8 = 1'b0;
        step();
        $display("div8 a=%h b=%h s=%0d -> res=%h lat=%0d", a, b, s, res, lat);
    endtask

    // Start a 100/7 division and kill it after at_cnt steps by annul or reset.
    task automatic abort32(input bit use_rst, input int at_cnt);
        start32 = 1'b1; a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0;
        repeat (at_cnt + 1) step();
        start32 = 1'b0;
        if (use_rst) rst = 1'b1; else annul32 = 1'b1;
        step();
        rst = 1'b0; annul32 = 1'b0;
        chk("abort_rdy", 64'(rdy32), 64'd0);
        chk("abort_res", res32, 64'd0);
        repeat (2) step();
        $display("abort32 rst=%0d cnt=%0d -> rdy=%0d", use_rst, at_cnt, rdy32);
    endtask

    function automatic logic [31:0] pick32(input int sel);
        case (sel)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            4: return $urandom_range(15, 1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] r, re;
        logic [15:0] r8;
        int lat;
        rst = 1'b1;
        start32 = 1'b0; annul32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; annul8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_rdy32", 64'(rdy32), 64'd0);
        chk("reset_res32", res32, 64'd0);

        run32(32'd100, 32'd7, 1'b0, 0, r, re, lat);
        chk("t1_res", r, 64'h0000_0002_0000_000E);
        chk("t1_lat", 64'(lat), 64'd33);
        run32(32'hFFFF_FF9C, 32'd7, 1'b1, 0, r, re, lat);
        chk("t2a_res", r, 64'hFFFF_FFFE_FFFF_FFF2);
        run32(32'd100, 32'hFFFF_FFF9, 1'b1, 0, r, re, lat);
        chk("t2b_res", r, 64'h0000_0002_FFFF_FFF2);
        run32(32'hFFFF_FFFF, 32'd2, 1'b0, 0, r, re, lat);
        chk("t3a_res", r, 64'h0000_0001_7FFF_FFFF);
        run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, r, re, lat);
        chk("t3b_res", r, 64'h0000_0000_8000_0000);
        run32(32'd1234, 32'd0, 1'b0, 0, r, re, lat);
        chk("t4_res", r, 64'd0);
        chk("t4_lat", 64'(lat), 64'd1);
        chk("t4_drop_rdy", 64'(rdy32), 64'd0);
        chk("t4_drop_res", res32, 64'd0);

        abort32(1'b0, 10);
        abort32(1'b1, 20);
        run32(32'd100, 32'd7, 1'b0, 5, r, re, lat);
        chk("t5_res", r, 64'h0000_0002_0000_000E);
        chk("t6_hold", re, 64'h0000_0002_0000_000E);

        run8(8'd200, 8'd3, 1'b0, r8, lat);
        chk("t6_res8", 64'(r8), 64'h0242);
        chk("t6_lat8", 64'(lat), 64'd9);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                abort32(1'($urandom), $urandom_range(31, 0));
            end else begin
                run32(pick32($urandom_range(9, 0)), pick32($urandom_range(9, 0)),
                      1'($urandom), $urandom_range(3, 0), r, re, lat);
            end
        end
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), (i % 6 == 0) ? 8'd0 : 8'($urandom), 1'($urandom), r8, lat);
        end
        run8(8'h80, 8'hFF, 1'b1, r8, lat);
        chk("t8_ovf", 64'(r8), 64'h0080);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Parametrised iterative radix-2 divider for the execute stage. It sits beside the combinational logic/shift result path and performs signed or unsigned DATA_W-bit division over DATA_W+1 cycles. The execute stage uses ready_o to hold the pipeline while a division is in flight. Results are written to HI/LO as {remainder, quotient}.

Parameters:
DATA_W, 32, operand width in bits; must be at least 4.
CNT_W, $clog2(DATA_W+1), iteration counter width; derived localparam, not overridable.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset; synchronous, active-high
start_i  input  1  request a division; level, held high by execute until ready_o is seen
annul_i  input  1  abort the in-flight division (flush or exception)
signed_div_i  input  1  1 = two's-complement division, 0 = unsigned
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
result_o  output  2*DATA_W  {remainder, quotient}; remainder in the upper half
ready_o  output  1  result_o valid

Behaviour:
- Reset: rst=1 at an edge forces state IDLE, result_o=0, ready_o=0 and clears all internal registers. Reset takes effect from any state, including mid-division.
- States: IDLE, BYZERO, ON, END. All outputs are registered.
- IDLE:
  - start_i=1 and annul_i=0 at an edge (the accept edge E0) latches the operands.
  - If opdata2_i==0, go to BYZERO. Otherwise go to ON with cnt=0.
  - start_i=1 together with annul_i=1 is ignored; the block stays in IDLE.
- Operand latch: when signed_div_i=1, negative operands are converted to magnitude (two's complement). The sign of the dividend, the sign of the divisor and the signed_div_i value are registered for the final correction.
- ON:
  - Each edge performs one restoring step on a (2*DATA_W+1)-bit partial remainder: shift left by 1, trial-subtract the divisor magnitude, and shift in a quotient bit of 1 if the difference is non-negative, else 0.
  - cnt increments once per step. After DATA_W steps (edges E1..E_DATA_W), the next edge E_DATA_W+1 applies the sign correction, loads result_o, sets ready_o=1 and moves to END.
  - Latency from the accept edge to ready_o=1 is DATA_W+1 edges.
- Sign correction (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Both are truncated to DATA_W bits.
  - Overflow case (-2^(DATA_W-1) / -1): quotient = 2^(DATA_W-1), i.e. 0x80000000 when DATA_W=32; remainder = 0. No trap is raised.
- BYZERO: the next edge loads result_o=0, sets ready_o=1 and moves to END. Total latency is 1 edge.
- END:
  - result_o and ready_o hold while start_i=1.
  - The first edge with start_i=0 moves to IDLE and clears ready_o and result_o to 0.
  - A new start therefore needs at least one start_i=0 cycle in between.
- annul_i:
  - annul_i=1 in ON or BYZERO at an edge moves to IDLE with ready_o=0 and result_o=0. No result is ever presented.
  - annul_i is ignored in END.
- Operand inputs are sampled only at E0. Later changes on the operand inputs or on signed_div_i have no effect.
- Simultaneous rst and annul_i: rst wins. The outcome is the same either way.

Optional Feature:
Macro DIV_BYZERO_FLAG_EN.
- Defined: adds output port divzero_o (1 bit).
  - Registered, reset 0.
  - Set to 1 on the BYZERO->END edge, together with ready_o.
  - Cleared on END->IDLE, on annul and on reset.
  - Stays 0 for every non-zero divisor.
- Not defined: the port does not exist. A zero divisor is only visible as result_o=0.

Test Plan:
1. DATA_W=32, unsigned 100/7 -> ready_o rises 33 edges after accept; result_o = {32'd2, 32'd14}.
2. Signed -100/7 (0xFFFFFF9C / 7) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100/-7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
3. Unsigned 0xFFFFFFFF/2 -> {0x00000001, 0x7FFFFFFF}. Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
4. Divisor 0 -> ready_o=1 after 1 edge, result_o=0. With DIV_BYZERO_FLAG_EN, divzero_o=1. Drop start_i -> all outputs 0 on the next edge.
5. annul_i pulsed at cnt=10, and in a separate run rst pulsed at cnt=20 -> IDLE on that edge, ready_o never asserted. A following 100/7 division completes normally.
6. Hold start_i high 5 cycles in END with operands changing -> result_o stable. Re-parametrise DATA_W=8: 200/3 unsigned -> {8'd2, 8'd66} after 9 edges.
